// File: rtl/reg_file_2r1w_pkg.sv
// Shared definitions for the 2-read/1-write register file: default sizes
// and the read-mode / bypass-mode encodings.
package rf_defs;

    localparam int RF_DEF_B = 8;
    localparam int RF_DEF_W = 2;

    localparam int RF_RD_COMB = 0;
    localparam int RF_RD_REG  = 1;

    localparam int RF_BYP_OFF = 0;
    localparam int RF_BYP_ON  = 1;

    function automatic int rf_depth(input int w);
        return 1 << w;
    endfunction

endpackage

// File: rtl/reg_file_2r1w_read_port.sv
// One read port: address mux, optional write-to-read bypass and optional
// output register that is cleared by the asynchronous reset.
module rf_read_port
    import rf_defs::*;
#(
    parameter int B      = RF_DEF_B,
    parameter int W      = RF_DEF_W,
    parameter int BYPASS = RF_BYP_ON,
    parameter int REG_RD = RF_RD_COMB
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [(2**W)-1:0][B-1:0]     mem,
    input  logic [(2**W)-1:0]            valid,
    input  logic                         wr_en,
    input  logic [W-1:0]                 w_addr,
    input  logic [B-1:0]                 w_data,
    input  logic [W-1:0]                 r_addr,
    output logic [B-1:0]                 r_data,
    output logic                         r_valid
);

    logic [B-1:0] sel_data;
    logic         sel_valid;

    generate
        if (BYPASS == RF_BYP_ON) begin : g_bypass
            always_comb begin
                sel_data  = mem[r_addr];
                sel_valid = valid[r_addr];
                if (wr_en && (w_addr == r_addr)) begin
                    sel_data  = w_data;
                    sel_valid = 1'b1;
                end
            end
        end else begin : g_no_bypass
            logic unused_wr;
            assign unused_wr = ^{wr_en, w_addr, w_data};
            always_comb begin
                sel_data  = mem[r_addr];
                sel_valid = valid[r_addr];
            end
        end
    endgenerate

    generate
        if (REG_RD == RF_RD_REG) begin : g_reg_rd
            // Selection sees pre-edge array contents, so a non-bypassed
            // write or clear in this cycle shows up one read later.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_data  <= sel_data;
                    r_valid <= sel_valid;
                end
            end
        end else begin : g_comb_rd
            logic unused_clk;
            assign unused_clk = ^{clk, rst_n};
            assign r_data  = sel_data;
            assign r_valid = sel_valid;
        end
    endgenerate

endmodule

// File: rtl/reg_file_2r1w.sv
// Register file with one write port, two independent read ports and a valid
// bit per entry; all storage is cleared by the asynchronous active-low reset.
module reg_file_2r1w
    import rf_defs::*;
#(
    parameter int B      = RF_DEF_B,
    parameter int W      = RF_DEF_W,
    parameter int BYPASS = RF_BYP_ON,
    parameter int REG_RD = RF_RD_COMB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] w_addr,
    input  logic [B-1:0] w_data,
    input  logic         clr,
    input  logic [W-1:0] ra_addr,
    input  logic [W-1:0] rb_addr,
    output logic [B-1:0] ra_data,
    output logic [B-1:0] rb_data,
    output logic         ra_valid,
    output logic         rb_valid
);

    localparam int DEPTH = rf_depth(W);

    logic [DEPTH-1:0][B-1:0] mem;
    logic [DEPTH-1:0]        valid;

    // The write's valid set is ordered after the clear so a simultaneous
    // write survives while every other entry is invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            valid <= '0;
        end else begin
            if (clr) begin
                valid <= '0;
            end
            if (wr_en) begin
                mem[w_addr]   <= w_data;
                valid[w_addr] <= 1'b1;
            end
        end
    end

    rf_read_port #(
        .B      (B),
        .W      (W),
        .BYPASS (BYPASS),
        .REG_RD (REG_RD)
    ) u_port_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem     (mem),
        .valid   (valid),
        .wr_en   (wr_en),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .r_addr  (ra_addr),
        .r_data  (ra_data),
        .r_valid (ra_valid)
    );

    rf_read_port #(
        .B      (B),
        .W      (W),
        .BYPASS (BYPASS),
        .REG_RD (REG_RD)
    ) u_port_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .mem     (mem),
        .valid   (valid),
        .wr_en   (wr_en),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .r_addr  (rb_addr),
        .r_data  (rb_data),
        .r_valid (rb_valid)
    );

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: three 8-bit configurations share one
// stimulus set, a 16-bit/16-entry instance is driven separately.
module tb_reg_file_2r1w;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] w_addr;
    logic [7:0] w_data;
    logic       clr;
    logic [1:0] ra_addr;
    logic [1:0] rb_addr;

    logic [7:0] c0_ra_data, c0_rb_data, c1_ra_data, c1_rb_data, r0_ra_data, r0_rb_data;
    logic       c0_ra_valid, c0_rb_valid, c1_ra_valid, c1_rb_valid, r0_ra_valid, r0_rb_valid;

    logic        x_wr_en;
    logic [3:0]  x_w_addr;
    logic [15:0] x_w_data;
    logic        x_clr;
    logic [3:0]  x_ra_addr;
    logic [3:0]  x_rb_addr;
    logic [15:0] x_ra_data, x_rb_data;
    logic        x_ra_valid, x_rb_valid;

    int checks;
    int failures;

    // Combinational read, no bypass
    reg_file_2r1w #(.B(8), .W(2), .BYPASS(0), .REG_RD(0)) u_c0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .clr(clr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(c0_ra_data), .rb_data(c0_rb_data),
        .ra_valid(c0_ra_valid), .rb_valid(c0_rb_valid)
    );

    // Combinational read, bypass
    reg_file_2r1w #(.B(8), .W(2), .BYPASS(1), .REG_RD(0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .clr(clr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(c1_ra_data), .rb_data(c1_rb_data),
        .ra_valid(c1_ra_valid), .rb_valid(c1_rb_valid)
    );

    // Registered read, no bypass
    reg_file_2r1w #(.B(8), .W(2), .BYPASS(0), .REG_RD(1)) u_r0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .clr(clr), .ra_addr(ra_addr), .rb_addr(rb_addr),
        .ra_data(r0_ra_data), .rb_data(r0_rb_data),
        .ra_valid(r0_ra_valid), .rb_valid(r0_rb_valid)
    );

    reg_file_2r1w #(.B(16), .W(4), .BYPASS(0), .REG_RD(0)) u_wide (
        .clk(clk), .rst_n(rst_n), .wr_en(x_wr_en), .w_addr(x_w_addr), .w_data(x_w_data),
        .clr(x_clr), .ra_addr(x_ra_addr), .rb_addr(x_rb_addr),
        .ra_data(x_ra_data), .rb_data(x_rb_data),
        .ra_valid(x_ra_valid), .rb_valid(x_rb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0; wr_en = 1'b0; w_addr = '0; w_data = '0; clr = 1'b0;
        ra_addr = '0; rb_addr = '0;
        x_wr_en = 1'b0; x_w_addr = '0; x_w_data = '0; x_clr = 1'b0;
        x_ra_addr = '0; x_rb_addr = '0;

        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_c0_ra_data",  c0_ra_data,  0);
        check("rst_c0_ra_valid", c0_ra_valid, 0);
        check("rst_r0_ra_data",  r0_ra_data,  0);
        check("rst_r0_rb_valid", r0_rb_valid, 0);
        check("rst_wide_data",   x_ra_data,   0);

        // Write 55 to addr 1; bypass instance sees it in the same cycle.
        wr_en = 1'b1; w_addr = 2'd1; w_data = 8'h55; ra_addr = 2'd1; rb_addr = 2'd2;
        #1;
        check("byp_same_cycle_data",  c1_ra_data,  8'h55);
        check("byp_same_cycle_valid", c1_ra_valid, 1);
        check("nobyp_same_cycle_data",  c0_ra_data,  8'h00);
        check("nobyp_same_cycle_valid", c0_ra_valid, 0);
        tick();
        w_addr = 2'd2; w_data = 8'hAA;
        #1;
        check("c0_after_write_a",    c0_ra_data,  8'h55);
        check("c0_after_write_av",   c0_ra_valid, 1);
        check("c0_b_before_write",   c0_rb_valid, 0);
        check("c1_b_bypass_aa",      c1_rb_data,  8'hAA);
        check("r0_a_old_value",      r0_ra_data,  8'h00);
        tick();
        wr_en = 1'b0;
        #1;
        check("c0_ra_55", c0_ra_data,  8'h55);
        check("c0_rb_aa", c0_rb_data,  8'hAA);
        check("c0_ra_v",  c0_ra_valid, 1);
        check("c0_rb_v",  c0_rb_valid, 1);
        check("r0_ra_55", r0_ra_data,  8'h55);
        check("r0_rb_inflight_valid", r0_rb_valid, 0);
        tick();
        check("r0_rb_aa",      r0_rb_data,  8'hAA);
        check("r0_rb_aa_valid", r0_rb_valid, 1);

        // Registered read latency: ra_addr 1 -> 2
        ra_addr = 2'd2;
        #1;
        check("r0_latency_hold", r0_ra_data, 8'h55);
        check("c0_addr_change",  c0_ra_data, 8'hAA);
        tick();
        check("r0_latency_new", r0_ra_data, 8'hAA);

        // Bypass scenario on addr 3
        wr_en = 1'b1; w_addr = 2'd3; w_data = 8'h3C; ra_addr = 2'd3; rb_addr = 2'd3;
        #1;
        check("byp3_ra",  c1_ra_data,  8'h3C);
        check("byp3_rb",  c1_rb_data,  8'h3C);
        check("byp3_rav", c1_ra_valid, 1);
        check("byp3_rbv", c1_rb_valid, 1);
        check("nobyp3_ra",  c0_ra_data,  8'h00);
        check("nobyp3_rb",  c0_rb_data,  8'h00);
        check("nobyp3_rbv", c0_rb_valid, 0);
        tick();
        wr_en = 1'b0;
        #1;
        check("r0_byp3_old",   r0_ra_data,  8'h00);
        check("r0_byp3_oldv",  r0_ra_valid, 0);
        check("c0_3_visible",  c0_ra_data,  8'h3C);
        check("c0_3_visiblev", c0_rb_valid, 1);
        tick();
        check("r0_3_visible", r0_rb_data, 8'h3C);

        // Fill addr 0 so all entries are valid
        wr_en = 1'b1; w_addr = 2'd0; w_data = 8'h77;
        tick();
        wr_en = 1'b0;
        ra_addr = 2'd0; rb_addr = 2'd1;
        tick();

        // Clear together with a write to entry 0
        clr = 1'b1; wr_en = 1'b1; w_addr = 2'd0; w_data = 8'h11;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        #1;
        check("clr_e0_data",   c0_ra_data,  8'h11);
        check("clr_e0_valid",  c0_ra_valid, 1);
        check("clr_e1_data",   c0_rb_data,  8'h55);
        check("clr_e1_valid",  c0_rb_valid, 0);
        check("r0_clr_pre_a",  r0_ra_data,  8'h77);
        check("r0_clr_pre_b",  r0_rb_valid, 1);
        ra_addr = 2'd2; rb_addr = 2'd3;
        #1;
        check("clr_e2_data",  c0_ra_data,  8'hAA);
        check("clr_e2_valid", c0_ra_valid, 0);
        check("clr_e3_data",  c0_rb_data,  8'h3C);
        check("clr_e3_valid", c0_rb_valid, 0);
        tick();
        check("r0_post_clr_valid", r0_ra_valid, 0);
        check("r0_post_clr_data",  r0_ra_data,  8'hAA);

        // Wide instance: 16-bit data, 16 entries
        x_wr_en = 1'b1; x_w_addr = 4'd0; x_w_data = 16'h1234;
        tick();
        x_w_addr = 4'd15; x_w_data = 16'hBEEF;
        tick();
        x_wr_en = 1'b0; x_ra_addr = 4'd15; x_rb_addr = 4'd0;
        #1;
        check("wide_a15_data",  x_ra_data,  16'hBEEF);
        check("wide_a15_valid", x_ra_valid, 1);
        check("wide_a0_data",   x_rb_data,  16'h1234);
        check("wide_a0_valid",  x_rb_valid, 1);
        x_rb_addr = 4'd14;
        #1;
        check("wide_a14_empty", x_rb_valid, 0);

        // Reset asserted mid clock-high with a write pending
        wr_en = 1'b1; w_addr = 2'd2; w_data = 8'hF0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_c0_ra",  c0_ra_data,  0);
        check("mid_rst_r0_ra",  r0_ra_data,  0);
        check("mid_rst_r0_rav", r0_ra_valid, 0);
        check("mid_rst_wide",   x_ra_data,   0);
        tick();
        wr_en = 1'b0;
        rst_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            ra_addr = 2'(a);
            rb_addr = 2'(3 - a);
            #1;
            check("post_rst_ra_data",  c0_ra_data,  0);
            check("post_rst_ra_valid", c0_ra_valid, 0);
            check("post_rst_rb_data",  c1_rb_data,  0);
        end

        // First write after release lands normally
        wr_en = 1'b1; w_addr = 2'd1; w_data = 8'h5A; ra_addr = 2'd1;
        tick();
        wr_en = 1'b0;
        #1;
        check("post_rst_write", c0_ra_data, 8'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
